// File: rtl/dds_pkg.sv
// Shared encodings for the keyed DDS source: modulation modes, config register
// addresses and the constant generator used to fill the sine table.
package dds_pkg;

    localparam logic [1:0] MODE_CW  = 2'd0;
    localparam logic [1:0] MODE_ASK = 2'd1;
    localparam logic [1:0] MODE_FSK = 2'd2;
    localparam logic [1:0] MODE_RSV = 2'd3;

    localparam logic [1:0] CFG_F0     = 2'd0;
    localparam logic [1:0] CFG_F1     = 2'd1;
    localparam logic [1:0] CFG_OFFSET = 2'd2;
    localparam logic [1:0] CFG_NONE   = 2'd3;

    localparam real PI = 3.14159265358979323846;

    // Elaboration-time only: rounded (half away from zero) full-scale sine entry k.
    function automatic int sine_entry(input int k, input int addr_w, input int data_w);
        real amp;
        real x;
        amp = real'((1 << (data_w - 1)) - 1);
        x   = amp * $sin(2.0 * PI * real'(k) / real'(1 << addr_w));
        if (x >= 0.0) return $rtoi(x + 0.5);
        return -$rtoi(0.5 - x);
    endfunction

endpackage

// File: rtl/sin_lut.sv
// Sine lookup table with a registered read: 1 cycle latency.
// No backpressure; a new address is accepted every cycle.
module sin_lut
    import dds_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] rom [DEPTH];

    for (genvar k = 0; k < DEPTH; k++) begin : g_rom
        localparam int ENTRY = sine_entry(k, ADDR_W, DATA_W);
        assign rom[k] = ENTRY[DATA_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) data <= '0;
        else     data <= rom[addr];
    end

endmodule

// File: rtl/dds_keyed_source.sv
// Keyed DDS sine source (CW / ASK / phase-continuous FSK): 2 cycles acc -> out_data.
// No backpressure; en freezes the phase and out_valid tracks en two cycles later.
module dds_keyed_source
    import dds_pkg::*;
#(
    parameter int                 PHASE_W = 32,
    parameter int                 ADDR_W  = 8,
    parameter int                 DATA_W  = 7,
    parameter logic [PHASE_W-1:0] F0_INIT = PHASE_W'(858993),
    parameter logic [PHASE_W-1:0] F1_INIT = PHASE_W'(1717986)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic [1:0]               mode,
    input  logic                     key,
    input  logic                     cfg_we,
    input  logic [1:0]               cfg_addr,
    input  logic [PHASE_W-1:0]       cfg_data,
    output logic signed [DATA_W-1:0] out_data,
    output logic                     out_valid,
    output logic                     wrap
);

    localparam logic [0:0] ST_OFF = 1'b0;
    localparam logic [0:0] ST_ON  = 1'b1;

    logic [PHASE_W-1:0] acc;
    logic [PHASE_W-1:0] f0;
    logic [PHASE_W-1:0] f1;
    logic [PHASE_W-1:0] fw;
    logic [PHASE_W:0]   sum;
    logic [ADDR_W-1:0]  offset;
    logic [ADDR_W-1:0]  lut_addr;
    logic [DATA_W-1:0]  lut_q;
    logic [0:0]         state;
    logic [0:0]         state_nxt;
    logic               en_d1;

    assign fw       = (mode == MODE_FSK && key) ? f1 : f0;
    assign sum      = {1'b0, acc} + {1'b0, fw};
    assign lut_addr = acc[PHASE_W-1 -: ADDR_W] + offset;

    // The accumulator adds the word registered before any same-edge config write.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc    <= '0;
            f0     <= F0_INIT;
            f1     <= F1_INIT;
            offset <= '0;
            wrap   <= 1'b0;
        end else begin
            if (en) acc <= sum[PHASE_W-1:0];
            wrap <= en & sum[PHASE_W];
            if (cfg_we) begin
                case (cfg_addr)
                    CFG_F0:     f0     <= cfg_data;
                    CFG_F1:     f1     <= cfg_data;
                    CFG_OFFSET: offset <= cfg_data[ADDR_W-1:0];
                    CFG_NONE:   ;
                endcase
            end
        end
    end

    // ASK keys only on a wrap so bursts start and stop at a zero crossing.
    always_comb begin
        state_nxt = state;
        case (mode)
            MODE_ASK: if (wrap) state_nxt = key ? ST_ON : ST_OFF;
            MODE_CW, MODE_FSK, MODE_RSV: state_nxt = ST_ON;
        endcase
    end

    sin_lut #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) u_lut (
        .clk (clk),
        .rst (rst),
        .addr(lut_addr),
        .data(lut_q)
    );

    // state lags acc by one cycle, exactly like lut_q, so gating lines up with the sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_OFF;
            en_d1     <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            state     <= state_nxt;
            en_d1     <= en;
            out_valid <= en_d1;
            out_data  <= (state == ST_ON) ? lut_q : '0;
        end
    end

endmodule

// File: tb/tb_dds_keyed_source.sv
// Randomized scoreboard bench for dds_keyed_source against a phase/rule model.
module tb_dds_keyed_source;

    localparam bit [1:0] M_CW  = 2'd0;
    localparam bit [1:0] M_ASK = 2'd1;
    localparam bit [1:0] M_FSK = 2'd2;
    localparam longint   F0_DEF = 858993;
    localparam longint   F1_DEF = 1717986;
    localparam longint   MOD    = 64'h1_0000_0000;
    localparam real      PI_R   = 3.14159265358979323846;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              en = 1'b0;
    logic [1:0]        mode = 2'd0;
    logic              key = 1'b0;
    logic              cfg_we = 1'b0;
    logic [1:0]        cfg_addr = 2'd0;
    logic [31:0]       cfg_data = 32'd0;
    logic signed [6:0] out_data;
    logic              out_valid;
    logic              wrap;

    dds_keyed_source dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .mode     (mode),
        .key      (key),
        .cfg_we   (cfg_we),
        .cfg_addr (cfg_addr),
        .cfg_data (cfg_data),
        .out_data (out_data),
        .out_valid(out_valid),
        .wrap     (wrap)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Consequences of the inputs applied in cycle tag: wrap at tag+1, data/valid at tag+2.
    typedef struct {
        int tag;
        int data;
        bit valid;
        bit wrap;
    } exp_t;

    exp_t   sb_q[$];
    int     wrap_cycles[$];
    int     n_checks = 0;
    int     n_pass = 0;
    bit     wrap_prev = 1'b0;

    longint m_phase, m_f0, m_f1;
    int     m_off;
    bit     m_gate, m_wrap;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s @cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    endtask

    task automatic check_range(input string name, input longint act, input longint lo, input longint hi);
        n_checks++;
        if (act >= lo && act <= hi) n_pass++;
        else $display("FAIL %s @cycle %0d: got %0d, expected %0d..%0d", name, cyc, act, lo, hi);
    endtask

    task automatic check_periods(input string name, input int lo, input int hi, input int min_wraps);
        check_range({name, "_wrap_count"}, wrap_cycles.size(), min_wraps, 1000);
        for (int i = 1; i < wrap_cycles.size(); i++)
            check_range(name, wrap_cycles[i] - wrap_cycles[i-1], lo, hi);
    endtask

    function automatic int ref_sine(input int k);
        real x;
        x = 63.0 * $sin(2.0 * PI_R * real'(k) / 256.0);
        return int'(x);
    endfunction

    // Drive one cycle of inputs and predict its effects from the behavioural rules.
    task automatic step(input bit r, input bit e, input bit [1:0] m, input bit k,
                        input bit we, input bit [1:0] a, input bit [31:0] d);
        exp_t   x;
        exp_t   y;
        longint fw;
        longint sum;
        bit     gate_nxt;
        @(posedge clk);
        #1;
        rst = r; en = e; mode = m; key = k; cfg_we = we; cfg_addr = a; cfg_data = d;
        x.tag = cyc;
        if (r) begin
            if (sb_q.size() > 0 && sb_q[sb_q.size()-1].tag == cyc - 1) begin
                y = sb_q.pop_back();
                y.data  = 0;
                y.valid = 1'b0;
                sb_q.push_back(y);
            end
            x.data = 0; x.valid = 1'b0; x.wrap = 1'b0;
            m_phase = 0; m_f0 = F0_DEF; m_f1 = F1_DEF; m_off = 0;
            m_gate = 1'b0; m_wrap = 1'b0;
        end else begin
            fw       = (m == M_FSK && k) ? m_f1 : m_f0;
            gate_nxt = (m == M_ASK) ? (m_wrap ? k : m_gate) : 1'b1;
            x.data   = gate_nxt ? ref_sine(int'(((m_phase >> 24) + m_off) % 256)) : 0;
            x.valid  = e;
            sum      = m_phase + fw;
            x.wrap   = e && (sum >= MOD);
            if (e) m_phase = sum % MOD;
            if (we) begin
                case (a)
                    2'd0:    m_f0 = d;
                    2'd1:    m_f1 = d;
                    2'd2:    m_off = int'(d % 256);
                    default: ;
                endcase
            end
            m_gate = gate_nxt;
            m_wrap = x.wrap;
        end
        sb_q.push_back(x);
    endtask

    always @(negedge clk) begin
        exp_t x;
        if (sb_q.size() > 0 && sb_q[0].tag == cyc - 2) begin
            x = sb_q.pop_front();
            check("out_data", out_data, x.data);
            check("out_valid", out_valid, x.valid);
            check("wrap", wrap_prev, x.wrap);
        end
        if (wrap) wrap_cycles.push_back(cyc);
        wrap_prev = wrap;
    end

    initial begin
        int w, nz, amax, prev, cur, maxd, lowv;
        bit r_rst, r_en, r_we, r_key;
        bit [1:0] r_mode, r_addr;
        bit [31:0] r_data;

        // Reset state, then CW with default f0.
        step(1'b1, 1'b1, M_CW, 1'b0, 1'b1, 2'd0, 32'd77);
        step(1'b1, 1'b1, M_CW, 1'b0, 1'b0, 2'd0, 32'd0);
        check("reset_out_data", out_data, 0);
        check("reset_out_valid", out_valid, 0);
        check("reset_wrap", wrap, 0);
        wrap_cycles.delete();
        step(1'b0, 1'b1, M_CW, 1'b0, 1'b0, 2'd0, 32'd0);
        check("valid_c1", out_valid, 0);
        step(1'b0, 1'b1, M_CW, 1'b0, 1'b0, 2'd0, 32'd0);
        check("valid_c2", out_valid, 0);
        step(1'b0, 1'b1, M_CW, 1'b0, 1'b0, 2'd0, 32'd0);
        check("valid_c3", out_valid, 1);
        repeat (11000) step(1'b0, 1'b1, M_CW, 1'b0, 1'b0, 2'd0, 32'd0);
        check_periods("cw_period", 4999, 5001, 2);

        // Quarter-period phase offset.
        step(1'b1, 1'b1, M_CW, 1'b0, 1'b0, 2'd0, 32'd0);
        step(1'b0, 1'b1, M_CW, 1'b0, 1'b1, 2'd2, 32'd64);
        repeat (3) step(1'b0, 1'b1, M_CW, 1'b0, 1'b0, 2'd0, 32'd0);
        check("offset_first_sample", out_data, 63);
        repeat (300) step(1'b0, 1'b1, M_CW, 1'b0, 1'b0, 2'd0, 32'd0);

        // FSK: key=0 then key=1, phase-continuous.
        wrap_cycles.delete();
        repeat (10100) step(1'b0, 1'b1, M_FSK, 1'b0, 1'b0, 2'd0, 32'd0);
        check_periods("fsk_f0_period", 4999, 5001, 2);
        wrap_cycles.delete();
        prev = int'(out_data);
        maxd = 0;
        for (int i = 0; i < 7600; i++) begin
            step(1'b0, 1'b1, M_FSK, 1'b1, 1'b0, 2'd0, 32'd0);
            cur = int'(out_data);
            if (cur - prev > maxd) maxd = cur - prev;
            if (prev - cur > maxd) maxd = prev - cur;
            prev = cur;
        end
        check_periods("fsk_f1_period", 2499, 2501, 3);
        check_range("fsk_max_step", maxd, 0, 2);

        // ASK with a 200-cycle period: key rises mid-period.
        step(1'b1, 1'b1, M_CW, 1'b0, 1'b0, 2'd0, 32'd0);
        step(1'b0, 1'b1, M_CW, 1'b0, 1'b1, 2'd0, 32'd21474836);
        repeat (450) step(1'b0, 1'b1, M_ASK, 1'b0, 1'b0, 2'd0, 32'd0);
        if (m_wrap) step(1'b0, 1'b1, M_ASK, 1'b0, 1'b0, 2'd0, 32'd0);
        w = -1; nz = 0; amax = -100;
        for (int i = 0; i < 400; i++) begin
            step(1'b0, 1'b1, M_ASK, 1'b1, 1'b0, 2'd0, 32'd0);
            if (w < 0 || cyc <= w + 1) begin
                if (out_data != 0) nz++;
            end else if (cyc == w + 2) begin
                check_range("ask_first_sample", out_data, -2, 2);
            end else if (cyc <= w + 20 && int'(out_data) > amax) begin
                amax = int'(out_data);
            end
            if (w < 0 && m_wrap) w = cyc + 1;
        end
        check("ask_wrap_found", w >= 0, 1);
        check("ask_gated_zero", nz, 0);
        check_range("ask_rising", amax, 1, 63);
        r_key = 1'b1;
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 59) == 0) r_key = ~r_key;
            step(1'b0, 1'b1, M_ASK, r_key, 1'b0, 2'd0, 32'd0);
        end

        // en low for 10 cycles.
        step(1'b1, 1'b1, M_CW, 1'b0, 1'b0, 2'd0, 32'd0);
        repeat (20) step(1'b0, 1'b1, M_CW, 1'b0, 1'b0, 2'd0, 32'd0);
        lowv = 0;
        for (int i = 0; i < 40; i++) begin
            step(1'b0, !(i < 10), M_CW, 1'b0, 1'b0, 2'd0, 32'd0);
            if (!out_valid) lowv++;
        end
        check("en_gap_valid_low", lowv, 10);

        // Random mix of modes, keys, enables, config writes and resets.
        r_key = 1'b0;
        for (int i = 0; i < 6000; i++) begin
            r_rst  = ($urandom_range(0, 799) == 0);
            r_en   = ($urandom_range(0, 9) != 0);
            r_mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 49) == 0) r_key = ~r_key;
            r_we   = ($urandom_range(0, 29) == 0);
            r_addr = 2'($urandom_range(0, 3));
            r_data = (r_addr < 2'd2) ? 32'($urandom_range(1000000, 60000000)) : 32'($urandom);
            step(r_rst, r_en, r_mode, r_key, r_we, r_addr, r_data);
        end

        // Reset mid-run overrides en and cfg_we.
        step(1'b0, 1'b1, M_FSK, 1'b1, 1'b0, 2'd0, 32'd0);
        step(1'b1, 1'b1, M_FSK, 1'b1, 1'b1, 2'd2, 32'd100);
        step(1'b0, 1'b1, M_CW, 1'b0, 1'b0, 2'd0, 32'd0);
        check("midrun_rst_out_data", out_data, 0);
        check("midrun_rst_out_valid", out_valid, 0);
        check("midrun_rst_wrap", wrap, 0);
        repeat (300) step(1'b0, 1'b1, M_CW, 1'b0, 1'b0, 2'd0, 32'd0);
        repeat (3) step(1'b0, 1'b1, M_CW, 1'b0, 1'b0, 2'd0, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/dds_keyed_source.md
DDS_KEYED_SOURCE -- requirements
Module: dds_keyed_source

Interface
REQ-001 SHALL have parameter PHASE_W, 32, phase accumulator width in bits.
REQ-002 SHALL have parameter ADDR_W, 8, sine table address width (2^ADDR_W entries per period).
REQ-003 SHALL have parameter DATA_W, 7, signed sample width.
REQ-004 SHALL have parameter F0_INIT, 858993, reset value of frequency word f0 (10 kHz at 50 MHz, PHASE_W=32).
REQ-005 SHALL have parameter F1_INIT, 1717986, reset value of frequency word f1 (20 kHz at 50 MHz).
REQ-006 SHALL have port clk, input, 1, sole clock; all logic on rising edge.
REQ-007 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-008 SHALL have port en, input, 1, accumulator advance enable.
REQ-009 SHALL have port mode, input, 2, 0=CW, 1=ASK, 2=FSK, 3=reserved (treated as CW).
REQ-010 SHALL have port key, input, 1, modulating bit.
REQ-011 SHALL have port cfg_we, input, 1, configuration write strobe.
REQ-012 SHALL have port cfg_addr, input, 2, 0=f0, 1=f1, 2=phase offset, 3=ignored.
REQ-013 SHALL have port cfg_data, input, PHASE_W, write data; phase offset uses bits [ADDR_W-1:0].
REQ-014 SHALL have port out_data, output, DATA_W, signed two's-complement sample.
REQ-015 SHALL have port out_valid, output, 1, out_data is a valid pipelined sample.
REQ-016 SHALL have port wrap, output, 1, one-cycle pulse on accumulator carry-out.

Function
REQ-017 Active frequency word fw SHALL be f1 when mode=FSK and key=1, otherwise f0.
REQ-018 When en=1 the accumulator SHALL update acc <= acc + fw modulo 2^PHASE_W each cycle; when en=0 acc holds.
REQ-019 FSK switching SHALL be phase-continuous: acc never cleared on key change.
REQ-020 Table address SHALL be acc[PHASE_W-1 -: ADDR_W] + offset modulo 2^ADDR_W.
REQ-021 Table entry k SHALL equal round((2^(DATA_W-1)-1)*sin(2*pi*k/2^ADDR_W)).
REQ-022 Pipeline: acc register -> table read register -> output register; out_data SHALL reflect acc value from 2 cycles earlier.
REQ-023 out_valid SHALL equal en delayed by 2 cycles, forced 0 while that delay line holds reset values.
REQ-024 wrap SHALL pulse 1 in the cycle after an enabled update whose addition carried out of bit PHASE_W-1.
REQ-025 Gate FSM states OFF, ON; in OFF out_data SHALL be 0 (gating applied at output register, aligned with pipeline).
REQ-026 mode CW/FSK/reserved: FSM SHALL enter ON the next cycle regardless of key.
REQ-027 mode ASK: OFF->ON only when key=1 in a cycle with wrap=1; ON->OFF only when key=0 in a cycle with wrap=1; otherwise hold.
REQ-028 Config write SHALL update the addressed register at the clock edge; new f0/f1 used from the next accumulator update, new offset from the next table read.
REQ-029 cfg_we with cfg_addr=3 SHALL change nothing.
REQ-030 Simultaneous cfg write of the active word and accumulator update: update SHALL use the old word.
REQ-031 Mode change mid-operation SHALL NOT disturb acc; FSM applies new mode rules from the next cycle.

Reset
REQ-032 rst SHALL set acc=0, f0=F0_INIT, f1=F1_INIT, offset=0, FSM=OFF, out_data=0, out_valid=0, wrap=0, delay lines 0.
REQ-033 rst asserted mid-operation SHALL take effect at the next edge, overriding en and cfg_we.

Structure
REQ-034 Mode encodings and cfg address constants SHALL live in shared package dds_pkg.
REQ-035 Sine table SHALL be sub-module sin_lut (ADDR_W, DATA_W parameters, 1-cycle registered read).

Verification
REQ-036 Reset, mode=CW, en=1, default f0: out_valid=1 from third cycle after rst release; wrap period 5000 +/-1 cycles.
REQ-037 Write cfg_addr=2 data=64 (ADDR_W=8): output sequence shifted by quarter period (first sample after update = +63).
REQ-038 mode=FSK, toggle key 0->1: wrap period drops from ~5000 to ~2500 cycles, no sample discontinuity > one f1 step.
REQ-039 mode=ASK, key rises mid-period: out_data stays 0 until 2 cycles after next wrap, then sine starting near 0.
REQ-040 en=0 for 10 cycles: acc frozen, out_valid low 2 cycles later for 10 cycles; rst mid-run returns all outputs to 0 next edge.
